// File: rtl/weight_pkg.sv
// weight_pkg: loader state encoding and checksum width shared by the weight-load path.
package weight_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  localparam int CSUM_W = 16;
endpackage

// File: rtl/weight_loader_1x1.sv
// weight_loader_1x1: streams DEPTH weight elements into a flat RAM, one registered write per accepted element.
// Define WEIGHT_LOADER_CHECKSUM_EN to build the running 16-bit checksum; otherwise checksum is tied to 0.
module weight_loader_1x1
  import weight_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_CHANNELS = 3,
  parameter int OUT_CHANNELS = 5,
  parameter int DEPTH = IN_CHANNELS * OUT_CHANNELS,
  localparam int AW = $clog2(DEPTH),
  localparam int IW = IN_CHANNELS > 1 ? $clog2(IN_CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [AW-1:0]         wr_addr,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  row_done,
  output logic                  done,
  output logic [CSUM_W-1:0]     checksum
);
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, wr_addr_q, wr_addr_d;
  logic [IW-1:0] ic_q, ic_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, row_done_q, row_done_d, done_q, done_d;
  logic kick, acc, last, row_end;
  always_comb begin
    kick = state_q == IDLE && start;
    acc = state_q == LOAD && s_valid;
    last = cnt_q == AW'(DEPTH - 1);
    row_end = ic_q == IW'(IN_CHANNELS - 1);
    state_d = state_q == IDLE ? (start ? LOAD : IDLE) :
              state_q == LOAD ? (acc && last ? DONE : LOAD) : IDLE;
    cnt_d = kick ? '0 : acc ? cnt_q + AW'(1) : cnt_q;
    ic_d = kick || (acc && row_end) ? '0 : acc ? ic_q + IW'(1) : ic_q;
    wr_en_d = acc;
    wr_data_d = acc ? s_data : wr_data_q;
    wr_addr_d = acc ? cnt_q : wr_addr_q;
    row_done_d = acc && row_end;
    done_d = acc && last;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ic_q <= '0;
      wr_en_q <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      row_done_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ic_q <= ic_d;
      wr_en_q <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      row_done_q <= row_done_d;
      done_q <= done_d;
    end
  end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] checksum_q, checksum_d;
  always_comb checksum_d = kick ? '0 : acc ? checksum_q + CSUM_W'(s_data) : checksum_q;
  always_ff @(posedge clk) begin
    if (!rst_n) checksum_q <= '0;
    else checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif
  assign s_ready = state_q == LOAD;
  assign busy = state_q == LOAD || state_q == DONE;
  assign wr_en = wr_en_q;
  assign wr_data = wr_data_q;
  assign wr_addr = wr_addr_q;
  assign row_done = row_done_q;
  assign done = done_q;
endmodule

// File: tb/tb_weight_loader_1x1.sv
// tb_weight_loader_1x1: directed self-checking bench for weight_loader_1x1 with default parameters.
module tb_weight_loader_1x1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic s_ready, wr_en, busy, row_done, done;
  logic [7:0] wr_data;
  logic [3:0] wr_addr;
  logic [15:0] checksum;
  int checks = 0, errors = 0, wr_total = 0, done_total = 0;
  weight_loader_1x1 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .busy(busy), .row_done(row_done), .done(done), .checksum(checksum)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_en) wr_total++;
    if (done) done_total++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic st, input logic v, input logic [7:0] d);
    start = st;
    s_valid = v;
    s_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_sready"}, 32'(s_ready), 0);
    chk({tag, "_wren"}, 32'(wr_en), 0);
    chk({tag, "_addr"}, 32'(wr_addr), 0);
    chk({tag, "_data"}, 32'(wr_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rowdone"}, 32'(row_done), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_csum"}, 32'(checksum), 0);
  endtask
  task automatic full_load(input string tag, input logic [7:0] base, input int start_at);
    int sum = 0;
    for (int i = 0; i < 15; i++) begin
      step(i == start_at, 1'b1, base + 8'(i));
      sum += base + i;
      chk({tag, "_wren"}, 32'(wr_en), 1);
      chk({tag, "_addr"}, 32'(wr_addr), i);
      chk({tag, "_data"}, 32'(wr_data), base + i);
      chk({tag, "_rowdone"}, 32'(row_done), (i % 3 == 2) ? 1 : 0);
      chk({tag, "_done"}, 32'(done), (i == 14) ? 1 : 0);
      chk({tag, "_csum"}, 32'(checksum), CS ? (sum & 16'hffff) : 0);
    end
    chk({tag, "_busy_done"}, 32'(busy), 1);
    chk({tag, "_sready_done"}, 32'(s_ready), 0);
  endtask
  initial begin
    int w0, d0, k, c;
    step(0, 0, 0);
    step(0, 1, 8'h55);
    chk_zero("reset");
    rst_n = 1'b1;
    step(1, 0, 0);
    chk("t1_sready", 32'(s_ready), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_nowr", 32'(wr_en), 0);
    w0 = wr_total;
    d0 = done_total;
    full_load("t1", 8'h01, -1);
    chk("t1_csum_final", 32'(checksum), CS ? 32'h78 : 0);
    step(0, 0, 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_done", 32'(done), 0);
    chk("t1_idle_wren", 32'(wr_en), 0);
    chk("t1_csum_hold", 32'(checksum), CS ? 32'h78 : 0);
    chk("t1_writes", 32'(wr_total - w0), 15);
    chk("t1_dones", 32'(done_total - d0), 1);
    // s_valid toggled 1-0-0-1: writes only on acceptances, contiguous addresses
    step(1, 0, 0);
    w0 = wr_total;
    d0 = done_total;
    k = 0;
    c = 0;
    while (k < 15 && c < 100) begin
      step(0, (c % 4 == 0) || (c % 4 == 3), 8'h40 + 8'(k));
      chk("t2_wren", 32'(wr_en), ((c % 4 == 0) || (c % 4 == 3)) ? 1 : 0);
      if ((c % 4 == 0) || (c % 4 == 3)) begin
        chk("t2_addr", 32'(wr_addr), k);
        chk("t2_data", 32'(wr_data), 8'h40 + k);
        k++;
      end
      c++;
    end
    chk("t2_accepted", k, 15);
    chk("t2_done", 32'(done), 1);
    step(0, 1, 8'hee);
    step(0, 1, 8'hee);
    chk("t2_writes", 32'(wr_total - w0), 15);
    chk("t2_dones", 32'(done_total - d0), 1);
    // start pulsed mid-load and in the DONE cycle must be ignored
    step(1, 0, 0);
    w0 = wr_total;
    d0 = done_total;
    full_load("t3", 8'h20, 7);
    step(1, 1, 8'h99);
    step(0, 1, 8'h99);
    step(0, 1, 8'h99);
    chk("t3_norearm_busy", 32'(busy), 0);
    chk("t3_norearm_sready", 32'(s_ready), 0);
    chk("t3_writes", 32'(wr_total - w0), 15);
    chk("t3_dones", 32'(done_total - d0), 1);
    // reset in the middle of a load, then a clean reload
    step(1, 0, 0);
    w0 = wr_total;
    for (int i = 0; i < 7; i++) step(0, 1, 8'h30 + 8'(i));
    chk("t4_pre_addr", 32'(wr_addr), 6);
    rst_n = 1'b0;
    step(0, 1, 8'h77);
    chk_zero("t4_rst");
    rst_n = 1'b1;
    step(0, 1, 8'h77);
    chk("t4_writes", 32'(wr_total - w0), 7);
    chk("t4_idle_sready", 32'(s_ready), 0);
    step(1, 0, 0);
    full_load("t4", 8'h10, -1);
    chk("t4_csum_final", 32'(checksum), CS ? 32'h159 : 0);
    step(0, 0, 0);
    // s_valid held while IDLE: nothing consumed
    w0 = wr_total;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'hff);
      chk("t5_sready", 32'(s_ready), 0);
      chk("t5_wren", 32'(wr_en), 0);
      chk("t5_csum", 32'(checksum), CS ? 32'h159 : 0);
    end
    chk("t5_writes", 32'(wr_total - w0), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_loader_1x1.md
WEIGHT_LOADER_1X1 -- requirements
Module: weight_loader_1x1

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, weight element width in bits.
REQ-002 SHALL have parameter IN_CHANNELS, default 3, input channels per output-channel row.
REQ-003 SHALL have parameter OUT_CHANNELS, default 5, number of rows.
REQ-004 SHALL have parameter DEPTH, default IN_CHANNELS*OUT_CHANNELS, total elements; DEPTH >= 2.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a full load.
REQ-008 SHALL have port s_data  input  DATA_WIDTH  incoming weight element.
REQ-009 SHALL have port s_valid  input  1  s_data valid.
REQ-010 SHALL have port s_ready  output  1  loader accepts s_data this cycle.
REQ-011 SHALL have port wr_data  output  DATA_WIDTH  element to weight RAM.
REQ-012 SHALL have port wr_addr  output  $clog2(DEPTH)  flat RAM address.
REQ-013 SHALL have port wr_en  output  1  RAM write strobe.
REQ-014 SHALL have port busy  output  1  high in LOAD and DONE states.
REQ-015 SHALL have port row_done  output  1  one-cycle pulse with the write of the last element of each row.
REQ-016 SHALL have port done  output  1  one-cycle pulse with the write of element DEPTH-1.
REQ-017 SHALL have port checksum  output  16  running sum of loaded elements (see Configuration).

Function
REQ-018 SHALL implement states IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE on acceptance of element DEPTH-1; DONE->IDLE unconditionally next cycle.
REQ-019 SHALL drive s_ready = 1 only in LOAD; an element is accepted when s_valid && s_ready.
REQ-020 SHALL, for acceptance in cycle T, drive wr_en=1, wr_data=s_data, wr_addr=element index in cycle T+1 (1-cycle registered latency); wr_en=0 otherwise.
REQ-021 SHALL number elements 0..DEPTH-1 in arrival order, element index = oc*IN_CHANNELS + ic, ic fastest, matching the row layout the RAM read port returns per rd_addr.
REQ-022 SHALL assert row_done together with wr_en for indices with ic == IN_CHANNELS-1, and done together with wr_en for index DEPTH-1 (done cycle = DONE state).
REQ-023 SHALL ignore start in LOAD and DONE; start in DONE does not rearm.
REQ-024 SHALL hold the element counter when s_valid=0 in LOAD (gaps of any length allowed) and reset it to 0 on every IDLE->LOAD transition.
REQ-025 SHALL ignore s_valid outside LOAD; no element is consumed.
REQ-026 SHALL accept back-to-back elements at one per cycle with no bubbles.

Reset
REQ-027 SHALL, with rst_n=0 at a rising edge, enter IDLE, clear counter, and drive s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, row_done=0, done=0, checksum=0.
REQ-028 SHALL abort a load in progress on reset with no further writes; partially written RAM content is not restored.

Configuration
REQ-029 SHALL, with macro WEIGHT_LOADER_CHECKSUM_EN defined, clear checksum on IDLE->LOAD and add each accepted s_data (zero-extended, modulo 2^16) in the cycle after acceptance, final value valid in the done cycle and held until the next start.
REQ-030 SHALL, without WEIGHT_LOADER_CHECKSUM_EN, keep the checksum port present and constant 0 with no adder logic.

Structure
REQ-031 SHALL place the state enumeration (IDLE, LOAD, DONE) and the checksum width constant (16) in shared package weight_pkg.
REQ-032 SHALL implement as a single module with no sub-modules; instantiated beside the weight RAM with wr_* connected directly.

Verification
REQ-033 SHALL cover: defaults, start then 15 contiguous valid elements 0x01..0x0F -> wr_addr 0..14 one cycle after each, row_done at addr 2,5,8,11,14, done with addr 14, checksum 0x0078.
REQ-034 SHALL cover: s_valid toggled 1-0-0-1 pattern -> writes only on acceptances, addresses contiguous, no duplicate or skipped address.
REQ-035 SHALL cover: start pulsed at element 7 and in the DONE cycle -> ignored; exactly 15 writes, single done pulse.
REQ-036 SHALL cover: rst_n=0 after element 6 -> all outputs 0 next cycle; new start loads addr 0..14 cleanly, checksum restarts from 0.
REQ-037 SHALL cover: s_valid=1 while IDLE for 10 cycles -> s_ready=0, no wr_en; with macro undefined checksum stays 0 throughout.
